// File: rtl/cache_control_l2.sv
// Sequencing controller for the two-way L2 cache datapath: hit response, victim
// writeback and line allocate, plus saturating hit/miss/writeback event counters.
module cache_control_l2 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit,
    input  logic             dirty,
    input  logic             pmem_resp,
    input  logic             clear_counters,
    output logic             mem_resp,
    output logic             sel_way_mux,
    output logic             pmem_mux_sel,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             miss_pending_q, miss_pending_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic [CNT_W-1:0] wb_count_q, wb_count_d;
    logic             req;
    logic             hit_inc, miss_inc, wb_inc;

    assign req = mem_read | mem_write;

    // Next state and state-decoded strobes; the hit response is combinational in IDLE.
    always_comb begin
        state_d        = state_q;
        miss_pending_d = miss_pending_q;
        mem_resp       = 1'b0;
        sel_way_mux    = 1'b0;
        pmem_mux_sel   = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        wb_inc         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !reset) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                    end else begin
                        miss_inc       = 1'b1;
                        miss_pending_d = 1'b1;
                        state_d        = dirty ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_mux_sel = 1'b1;
                sel_way_mux  = 1'b1;
                if (pmem_resp) begin
                    wb_inc  = 1'b1;
                    state_d = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                pmem_read   = 1'b1;
                sel_way_mux = 1'b1;
                if (pmem_resp) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The response that closes a miss must not be counted as a hit.
        if (mem_resp) begin
            hit_inc        = !miss_pending_q;
            miss_pending_d = 1'b0;
        end
    end

    // Saturating counters; a clear wins over a same-cycle increment.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (clear_counters) begin
            hit_count_d  = '0;
            miss_count_d = '0;
            wb_count_d   = '0;
        end else begin
            if (hit_inc && (hit_count_q != '1))
                hit_count_d = hit_count_q + CNT_W'(1);
            if (miss_inc && (miss_count_q != '1))
                miss_count_d = miss_count_q + CNT_W'(1);
            if (wb_inc && (wb_count_q != '1))
                wb_count_d = wb_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            miss_pending_q <= 1'b0;
            hit_count_q    <= '0;
            miss_count_q   <= '0;
            wb_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            miss_pending_q <= miss_pending_d;
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
            wb_count_q     <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_control_l2.sv
// Randomized transaction-level bench for cache_control_l2 against a cycle-expectation
// model built from request/miss/writeback timing rules.
module tb_cache_control_l2;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_MAX = 65535;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_read, mem_write, hit, dirty, pmem_resp, clear_counters;
    logic             mem_resp, sel_way_mux, pmem_mux_sel, pmem_read, pmem_write;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_hit = 0, exp_miss = 0, exp_wb = 0;

    cache_control_l2 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .hit(hit), .dirty(dirty),
        .pmem_resp(pmem_resp), .clear_counters(clear_counters),
        .mem_resp(mem_resp), .sel_way_mux(sel_way_mux), .pmem_mux_sel(pmem_mux_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= int'(CNT_MAX)) ? v : v + 1;
    endfunction

    task automatic check_counters();
        check("hit_count",  32'(hit_count),  32'(exp_hit));
        check("miss_count", 32'(miss_count), 32'(exp_miss));
        check("wb_count",   32'(wb_count),   32'(exp_wb));
    endtask

    // One clock: drive inputs, check outputs, then fold this cycle's events into the model.
    task automatic step(input logic rd, input logic wr, input logic h, input logic d,
                        input logic pr, input logic clr,
                        input logic e_resp, input logic e_rd, input logic e_wr,
                        input logic e_mux, input logic e_sel,
                        input bit ev_hit, input bit ev_miss, input bit ev_wb);
        @(negedge clk);
        mem_read = rd; mem_write = wr; hit = h; dirty = d;
        pmem_resp = pr; clear_counters = clr;
        #2;
        check("mem_resp",     32'(mem_resp),     32'(e_resp));
        check("pmem_read",    32'(pmem_read),    32'(e_rd));
        check("pmem_write",   32'(pmem_write),   32'(e_wr));
        check("pmem_mux_sel", 32'(pmem_mux_sel), 32'(e_mux));
        check("sel_way_mux",  32'(sel_way_mux),  32'(e_sel));
        check_counters();
        if (clr) begin
            exp_hit = 0; exp_miss = 0; exp_wb = 0;
        end else begin
            if (ev_hit)  exp_hit  = sat_inc(exp_hit);
            if (ev_miss) exp_miss = sat_inc(exp_miss);
            if (ev_wb)   exp_wb   = sat_inc(exp_wb);
        end
    endtask

    task automatic idle_cycle(input bit allow_clr);
        logic clr;
        clr = allow_clr && ($urandom_range(0, 15) == 0);
        step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), clr,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One complete request; wb_len==0 means a clean miss, fill_len is ALLOCATE length.
    task automatic txn(input logic rd, input logic wr, input bit is_hit,
                       input int wb_len, input int fill_len);
        if (is_hit) begin
            step(rd, wr, 1'b1, 1'($urandom), 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end else begin
            step(rd, wr, 1'b0, (wb_len > 0), 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            for (int i = 1; i <= wb_len; i++)
                step(rd, wr, 1'($urandom), 1'($urandom), (i == wb_len), 1'b0,
                     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, (i == wb_len));
            for (int i = 1; i <= fill_len; i++)
                step(rd, wr, 1'($urandom), 1'($urandom), (i == fill_len), 1'b0,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step(rd, wr, 1'b1, 1'($urandom), 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; dirty = 1'b0;
        pmem_resp = 1'b0; clear_counters = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_mem_resp",   32'(mem_resp),   32'd0);
        check("rst_pmem_read",  32'(pmem_read),  32'd0);
        check("rst_pmem_write", 32'(pmem_write), 32'd0);
        check("rst_mux",        32'(pmem_mux_sel), 32'd0);
        check("rst_sel",        32'(sel_way_mux),  32'd0);
        check_counters();
        @(negedge clk);
        reset = 1'b0;

        // Directed: read hit, clean read miss (k=3), dirty write miss, spurious pmem_resp.
        txn(1'b1, 1'b0, 1'b1, 0, 1);
        txn(1'b1, 1'b0, 1'b0, 0, 3);
        idle_cycle(1'b0);
        txn(1'b0, 1'b1, 1'b0, 2, 2);
        idle_cycle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        txn(1'b1, 1'b1, 1'b1, 0, 1);
        idle_cycle(1'b0);

        // Randomized protocol-compliant traffic.
        for (int t = 0; t < 300; t++) begin
            logic [1:0] kind;
            bit         is_hit;
            int         wbl;
            kind   = 2'($urandom_range(1, 3));
            is_hit = ($urandom_range(0, 2) == 0);
            wbl    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0;
            txn(kind[0], kind[1], is_hit, wbl, int'($urandom_range(1, 5)));
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_cycle(1'b1);
        end

        // Saturation: 0x10000 back-to-back hits, then clear coincident with a hit.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32'h10000; i++)
            txn(1'b1, 1'b0, 1'b1, 0, 1);
        idle_cycle(1'b0);
        check("hit_saturated", 32'(hit_count), 32'h0000_FFFF);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycle(1'b0);
        check("hit_cleared", 32'(hit_count), 32'd0);

        // Reset two cycles into WRITEBACK aborts the miss and clears everything.
        txn(1'b1, 1'b0, 1'b0, 0, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        #2;
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        check("rst_wb_pmem_write", 32'(pmem_write), 32'd0);
        check("rst_wb_pmem_read",  32'(pmem_read),  32'd0);
        check("rst_wb_mux",        32'(pmem_mux_sel), 32'd0);
        check_counters();
        @(negedge clk);
        reset = 1'b0;
        txn(1'b1, 1'b0, 1'b1, 0, 1);
        idle_cycle(1'b0);
        check("post_reset_hit", 32'(hit_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cache_control_l2.md
# cache_control_l2

Sequencing controller for the two-way, eight-line L2 cache datapath. It sits between the L1-side request port and the physical-memory port, and drives the datapath's way-select, address-select and memory-strobe controls. It also produces the single upstream response that updates the datapath LRU. Three saturating event counters (hits, misses, writebacks) are included for performance debug.

## Interface
- CNT_W, 16, width of each event counter

- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears the counters and the miss flag
- mem_read  in  1  upstream read request; held stable until mem_resp
- mem_write  in  1  upstream write request; held stable until mem_resp
- hit  in  1  datapath tag-match for the current index
- dirty  in  1  dirty bit of the replacement (non-LRU-used) way
- pmem_resp  in  1  physical memory completion strobe, one cycle
- clear_counters  in  1  synchronous clear of all three counters
- mem_resp  out  1  upstream response; also wired to the datapath real_mem_resp input (LRU update)
- sel_way_mux  out  1  0 = hit way, 1 = replacement way
- pmem_mux_sel  out  1  0 = request address, 1 = {victim tag, 4'b0} writeback address
- pmem_read  out  1  physical line read; also qualifies the datapath fill
- pmem_write  out  1  physical line write of the victim
- hit_count  out  CNT_W  accepted hit responses
- miss_count  out  CNT_W  misses detected
- wb_count  out  CNT_W  completed writebacks

## Operation
- Three states: IDLE, WRITEBACK, ALLOCATE. Reset state is IDLE. Every output resets to 0, and all counters reset to 0.
- Default outputs are all 0. Strobe outputs are decoded from state, with the hit response decoded from the inputs in IDLE.
- **IDLE**
  - With req = mem_read | mem_write, sel_way_mux = 0 and pmem_mux_sel = 0.
  - If req & hit: mem_resp = 1 in the same cycle and the state stays IDLE.
  - If req & !hit & dirty: go to WRITEBACK.
  - If req & !hit & !dirty: go to ALLOCATE.
  - On any req & !hit in IDLE, miss_count increments and miss_pending is set.
- **WRITEBACK**
  - pmem_write = 1, pmem_mux_sel = 1, sel_way_mux = 1.
  - On pmem_resp: go to ALLOCATE and increment wb_count.
- **ALLOCATE**
  - pmem_read = 1, pmem_mux_sel = 0, sel_way_mux = 1. The datapath fills the replacement way on pmem_resp.
  - On pmem_resp: go to IDLE. The next cycle sees hit = 1 and responds.
- **miss_pending flag**
  - Cleared on any mem_resp.
  - hit_count increments on mem_resp only when miss_pending = 0, so the post-fill response is not counted as a hit.
- **Counters**
  - Each counter saturates at all-ones (no wrap).
  - clear_counters has priority over any simultaneous increment.
- **Boundary rules**
  - pmem_resp while in IDLE is ignored.
  - mem_read and mem_write both high is treated as one write request: one response, counted once.
  - A request dropped before mem_resp is a protocol violation. The controller still finishes the memory sequence and then returns to IDLE.
  - reset asserted mid-WRITEBACK or mid-ALLOCATE immediately drops pmem_read and pmem_write and abandons the transaction. No counter increments for the aborted operation.

## Timing
- Hit latency: mem_resp in the same cycle as the request (combinational from hit).
- Clean miss:
  - Request at cycle 0 (miss_count +1); ALLOCATE from cycle 1.
  - pmem_resp at cycle k; IDLE at k+1 with mem_resp = 1.
  - Total latency is k+1 cycles.
- Dirty miss:
  - WRITEBACK from cycle 1; pmem_resp at cycle j; ALLOCATE from j+1.
  - Fill pmem_resp at m; mem_resp at m+1.
- pmem_read and pmem_write are never high together and are stable from state entry until the cycle of pmem_resp inclusive.
- mem_resp is high for exactly one cycle per request, given the requester drops the request after the response.
- Counter updates are visible the cycle after the triggering event.

## Test plan
- **Read hit after reset:** preload, then mem_read with hit = 1 → mem_resp high the same cycle, hit_count = 1, miss_count = 0, no pmem strobes.
- **Clean read miss:** hit = 0, dirty = 0, pmem_resp 3 cycles into ALLOCATE → pmem_read for 3 cycles with pmem_mux_sel = 0 and sel_way_mux = 1; mem_resp one cycle after pmem_resp; miss_count = 1, hit_count = 0.
- **Dirty write miss:**
  - Stimulus: mem_write, hit = 0, dirty = 1.
  - pmem_write with pmem_mux_sel = 1, then pmem_read with pmem_mux_sel = 0.
  - Result: wb_count = 1, miss_count = 1, exactly one mem_resp.
- **Saturation:** drive 0x10000 hits → hit_count = 0xFFFF. clear_counters asserted together with a hit → hit_count = 0.
- **Reset mid-WRITEBACK:** reset pulse two cycles into WRITEBACK → pmem_write = 0 immediately, state IDLE, all counters 0. A subsequent hit responds normally.
- **Spurious pmem_resp in IDLE:** no state change, no counter change.
